// File: rtl/decode_stage_if.sv
// Shared decode types plus the fetch/execute-facing bundle of the decode stage.
// The NOP encodings are all-zero so a freshly reset FIFO entry reads as a NOP.
package decode_pkg;
  typedef enum logic [3:0] {
    i_ALUNOP = 4'd0, i_ADD, i_SUB, i_SLL, i_SLT, i_SLTU, i_XOR, i_SRL, i_SRA, i_OR, i_AND
  } alu_op_t;

  typedef enum logic [3:0] {
    i_LSNOP = 4'd0, i_LB, i_LH, i_LW, i_LBU, i_LHU, i_SB, i_SH, i_SW
  } ls_op_t;

  localparam logic [3:0] i_JAL  = 4'b1000;
  localparam logic [3:0] i_JALR = 4'b1001;
endpackage

interface decode_stage_if #(parameter int CNT_W = 32);
  logic                    flush;
  logic                    in_valid;
  logic                    in_ready;
  logic [31:0]             in_instr;
  logic [31:0]             in_pc;
  logic                    out_valid;
  logic                    out_ready;
  logic [31:0]             out_pc;
  logic [4:0]              out_rd;
  logic [4:0]              out_rs1;
  logic [4:0]              out_rs2;
  decode_pkg::alu_op_t     out_alu_op;
  decode_pkg::ls_op_t      out_ls_op;
  logic [3:0]              out_br_op;
  logic [2:0]              out_mdu_op;
  logic                    out_is_alu;
  logic                    out_is_ls;
  logic                    out_is_br;
  logic                    out_is_mul;
  logic                    out_is_lui;
  logic                    out_is_auipc;
  logic                    out_is_imm;
  logic                    out_reg_we;
  logic [31:0]             out_imm;
  logic                    out_illegal;
  logic [CNT_W-1:0]        decoded_count;

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, out_alu_op, out_ls_op,
           out_br_op, out_mdu_op, out_is_alu, out_is_ls, out_is_br, out_is_mul, out_is_lui,
           out_is_auipc, out_is_imm, out_reg_we, out_imm, out_illegal, decoded_count
  );

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, out_alu_op, out_ls_op,
           out_br_op, out_mdu_op, out_is_alu, out_is_ls, out_is_br, out_is_mul, out_is_lui,
           out_is_auipc, out_is_imm, out_reg_we, out_imm, out_illegal, decoded_count
  );
endinterface

// File: rtl/decode_stage.sv
// RV32I(+M) decode stage: decodes in_instr combinationally and queues bundles in a FIFO.
// Latency: one cycle from push to out_valid; no combinational in_* to out_* path.
// Backpressure: in_ready = !full (no pass-through on pop); head held while out_ready=0.
module decode_stage #(
  parameter int FIFO_DEPTH = 2,
  parameter bit EN_M       = 1'b0,
  parameter int CNT_W      = 32
) (
  input logic           clk,
  input logic           reset,
  decode_stage_if.slave bus
);
  import decode_pkg::*;

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_REG    = 7'b0110011;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    alu_op_t     alu_op;
    ls_op_t      ls_op;
    logic [3:0]  br_op;
    logic [2:0]  mdu_op;
    logic        is_alu;
    logic        is_ls;
    logic        is_br;
    logic        is_mul;
    logic        is_lui;
    logic        is_auipc;
    logic        is_imm;
    logic        reg_we;
    logic [31:0] imm;
    logic        illegal;
  } bundle_t;

  logic [31:0] ins;
  logic [6:0]  opcode;
  logic [6:0]  f7;
  logic [2:0]  f3;
  logic [4:0]  rd;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        legal, writes;
  bundle_t     dec;
  bundle_t     head;
  bundle_t     mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, empty, push, pop;
  logic [CNT_W-1:0] count;

  assign ins    = bus.in_instr;
  assign opcode = ins[6:0];
  assign rd     = ins[11:7];
  assign f3     = ins[14:12];
  assign f7     = ins[31:25];
  assign imm_i  = {{20{ins[31]}}, ins[31:20]};
  assign imm_s  = {{20{ins[31]}}, ins[31:25], ins[11:7]};
  assign imm_b  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  assign imm_u  = {ins[31:12], 12'b0};
  assign imm_j  = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

  always_comb begin
    dec     = '0;
    legal   = 1'b0;
    writes  = 1'b0;
    dec.pc  = bus.in_pc;
    dec.rd  = rd;
    dec.rs1 = ins[19:15];
    dec.rs2 = ins[24:20];
    case (opcode)
      OPC_LUI:   begin legal = 1'b1; writes = 1'b1; dec.is_lui = 1'b1; dec.imm = imm_u; end
      OPC_AUIPC: begin legal = 1'b1; writes = 1'b1; dec.is_auipc = 1'b1; dec.imm = imm_u; end
      OPC_JAL: begin
        legal = 1'b1; writes = 1'b1; dec.is_br = 1'b1; dec.br_op = i_JAL; dec.imm = imm_j;
      end
      OPC_JALR: begin
        legal = (f3 == 3'b000); writes = 1'b1; dec.is_br = 1'b1; dec.br_op = i_JALR;
        dec.imm = imm_i;
      end
      OPC_BRANCH: begin
        legal = (f3[2:1] != 2'b01); dec.is_br = 1'b1; dec.br_op = {1'b0, f3}; dec.imm = imm_b;
      end
      OPC_LOAD: begin
        legal = 1'b1; writes = 1'b1; dec.is_ls = 1'b1; dec.imm = imm_i;
        case (f3)
          3'b000:  dec.ls_op = i_LB;
          3'b001:  dec.ls_op = i_LH;
          3'b010:  dec.ls_op = i_LW;
          3'b100:  dec.ls_op = i_LBU;
          3'b101:  dec.ls_op = i_LHU;
          default: legal = 1'b0;
        endcase
      end
      OPC_STORE: begin
        legal = 1'b1; dec.is_ls = 1'b1; dec.imm = imm_s;
        case (f3)
          3'b000:  dec.ls_op = i_SB;
          3'b001:  dec.ls_op = i_SH;
          3'b010:  dec.ls_op = i_SW;
          default: legal = 1'b0;
        endcase
      end
      OPC_IMM: begin
        legal = 1'b1; writes = 1'b1; dec.is_alu = 1'b1; dec.is_imm = 1'b1; dec.imm = imm_i;
        case (f3)
          3'b000: dec.alu_op = i_ADD;
          3'b010: dec.alu_op = i_SLT;
          3'b011: dec.alu_op = i_SLTU;
          3'b100: dec.alu_op = i_XOR;
          3'b110: dec.alu_op = i_OR;
          3'b111: dec.alu_op = i_AND;
          3'b001: begin dec.alu_op = i_SLL; legal = (f7 == 7'b0000000); end
          default: begin
            if (f7 == 7'b0000000)      dec.alu_op = i_SRL;
            else if (f7 == 7'b0100000) dec.alu_op = i_SRA;
            else                       legal = 1'b0;
          end
        endcase
      end
      OPC_REG: begin
        writes = 1'b1;
        if (EN_M && f7 == 7'b0000001) begin
          legal = 1'b1; dec.is_mul = 1'b1; dec.mdu_op = f3;
        end else if (f7 == 7'b0000000) begin
          legal = 1'b1; dec.is_alu = 1'b1;
          case (f3)
            3'b000:  dec.alu_op = i_ADD;
            3'b001:  dec.alu_op = i_SLL;
            3'b010:  dec.alu_op = i_SLT;
            3'b011:  dec.alu_op = i_SLTU;
            3'b100:  dec.alu_op = i_XOR;
            3'b101:  dec.alu_op = i_SRL;
            3'b110:  dec.alu_op = i_OR;
            default: dec.alu_op = i_AND;
          endcase
        end else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) begin
          legal = 1'b1; dec.is_alu = 1'b1;
          dec.alu_op = (f3 == 3'b000) ? i_SUB : i_SRA;
        end
      end
      default: ;
    endcase
    // Illegal instructions keep pc/fields/immediate but carry no class or op.
    if (!legal) begin
      dec.alu_op   = i_ALUNOP;
      dec.ls_op    = i_LSNOP;
      dec.br_op    = 4'b0;
      dec.mdu_op   = 3'b0;
      dec.is_alu   = 1'b0;
      dec.is_ls    = 1'b0;
      dec.is_br    = 1'b0;
      dec.is_mul   = 1'b0;
      dec.is_lui   = 1'b0;
      dec.is_auipc = 1'b0;
      dec.is_imm   = 1'b0;
    end
    dec.illegal = !legal;
    dec.reg_we  = legal && writes && (rd != 5'd0);
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push  = bus.in_valid && !full && !bus.flush;
  assign pop   = !empty && bus.out_ready && !bus.flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= dec;
        wr_ptr              <= wr_ptr + 1'b1;
        count               <= count + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign head              = mem[rd_ptr[AW-1:0]];
  assign bus.in_ready      = !full;
  assign bus.out_valid     = !empty;
  assign bus.out_pc        = head.pc;
  assign bus.out_rd        = head.rd;
  assign bus.out_rs1       = head.rs1;
  assign bus.out_rs2       = head.rs2;
  assign bus.out_alu_op    = head.alu_op;
  assign bus.out_ls_op     = head.ls_op;
  assign bus.out_br_op     = head.br_op;
  assign bus.out_mdu_op    = head.mdu_op;
  assign bus.out_is_alu    = head.is_alu;
  assign bus.out_is_ls     = head.is_ls;
  assign bus.out_is_br     = head.is_br;
  assign bus.out_is_mul    = head.is_mul;
  assign bus.out_is_lui    = head.is_lui;
  assign bus.out_is_auipc  = head.is_auipc;
  assign bus.out_is_imm    = head.is_imm;
  assign bus.out_reg_we    = head.reg_we;
  assign bus.out_imm       = head.imm;
  assign bus.out_illegal   = head.illegal;
  assign bus.decoded_count = count;
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: two instances (EN_M=0 / EN_M=1) share stimulus and are
// compared against an instruction-level decode model and a queue-based FIFO model.
module tb_decode_stage;
  import decode_pkg::*;

  localparam int DEPTH = 2;

  typedef struct packed {
    logic        valid;
    logic        ready;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    alu_op_t     alu;
    ls_op_t      ls;
    logic [3:0]  br;
    logic [2:0]  mdu;
    logic        is_alu;
    logic        is_ls;
    logic        is_br;
    logic        is_mul;
    logic        is_lui;
    logic        is_auipc;
    logic        is_imm;
    logic        reg_we;
    logic [31:0] imm;
    logic        illegal;
    logic [31:0] cnt;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, out_ready, flush;
  logic [31:0] in_instr, in_pc;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] q [$];
  logic [31:0] cnt;
  obs_t        obs0, obs1;

  always #5 clk = ~clk;

  decode_stage_if #(.CNT_W(32)) if0 ();
  decode_stage_if #(.CNT_W(32)) if1 ();

  assign if0.in_valid = in_valid;  assign if1.in_valid = in_valid;
  assign if0.in_instr = in_instr;  assign if1.in_instr = in_instr;
  assign if0.in_pc    = in_pc;     assign if1.in_pc    = in_pc;
  assign if0.out_ready = out_ready; assign if1.out_ready = out_ready;
  assign if0.flush    = flush;     assign if1.flush    = flush;

  decode_stage #(.FIFO_DEPTH(DEPTH), .EN_M(1'b0), .CNT_W(32)) dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
  decode_stage #(.FIFO_DEPTH(DEPTH), .EN_M(1'b1), .CNT_W(32)) dut1 (.clk(clk), .reset(reset), .bus(if1.slave));

  assign obs0 = {if0.out_valid, if0.in_ready, if0.out_pc, if0.out_rd, if0.out_rs1, if0.out_rs2,
                 if0.out_alu_op, if0.out_ls_op, if0.out_br_op, if0.out_mdu_op, if0.out_is_alu,
                 if0.out_is_ls, if0.out_is_br, if0.out_is_mul, if0.out_is_lui, if0.out_is_auipc,
                 if0.out_is_imm, if0.out_reg_we, if0.out_imm, if0.out_illegal, if0.decoded_count};
  assign obs1 = {if1.out_valid, if1.in_ready, if1.out_pc, if1.out_rd, if1.out_rs1, if1.out_rs2,
                 if1.out_alu_op, if1.out_ls_op, if1.out_br_op, if1.out_mdu_op, if1.out_is_alu,
                 if1.out_is_ls, if1.out_is_br, if1.out_is_mul, if1.out_is_lui, if1.out_is_auipc,
                 if1.out_is_imm, if1.out_reg_we, if1.out_imm, if1.out_illegal, if1.decoded_count};

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Instruction-level reference decode, written from the ISA tables.
  function automatic obs_t model_dec(logic [63:0] ent, bit en_m);
    obs_t        e = '0;
    logic [31:0] i = ent[63:32];
    logic [2:0]  f3 = i[14:12];
    logic [6:0]  f7 = i[31:25];
    bit          legal = 1'b0;
    bit          writes = 1'b0;
    alu_op_t     ops [8] = '{i_ADD, i_SLL, i_SLT, i_SLTU, i_XOR, i_SRL, i_OR, i_AND};
    ls_op_t      lds [8] = '{i_LB, i_LH, i_LW, i_LSNOP, i_LBU, i_LHU, i_LSNOP, i_LSNOP};
    ls_op_t      sts [8] = '{i_SB, i_SH, i_SW, i_LSNOP, i_LSNOP, i_LSNOP, i_LSNOP, i_LSNOP};
    logic [31:0] imm_i = {{20{i[31]}}, i[31:20]};
    e.pc = ent[31:0]; e.rd = i[11:7]; e.rs1 = i[19:15]; e.rs2 = i[24:20];
    case (i[6:0])
      7'h37: begin legal = 1; writes = 1; e.is_lui = 1; e.imm = {i[31:12], 12'h0}; end
      7'h17: begin legal = 1; writes = 1; e.is_auipc = 1; e.imm = {i[31:12], 12'h0}; end
      7'h6f: begin
        legal = 1; writes = 1; e.is_br = 1; e.br = i_JAL;
        e.imm = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
      end
      7'h67: begin legal = (f3 == 0); writes = 1; e.is_br = 1; e.br = i_JALR; e.imm = imm_i; end
      7'h63: begin
        legal = (f3 != 2 && f3 != 3); e.is_br = 1; e.br = {1'b0, f3};
        e.imm = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
      end
      7'h03: begin legal = (lds[f3] != i_LSNOP); writes = 1; e.is_ls = 1; e.ls = lds[f3]; e.imm = imm_i; end
      7'h23: begin
        legal = (sts[f3] != i_LSNOP); e.is_ls = 1; e.ls = sts[f3];
        e.imm = {{20{i[31]}}, i[31:25], i[11:7]};
      end
      7'h13: begin
        writes = 1; e.is_alu = 1; e.is_imm = 1; e.imm = imm_i; e.alu = ops[f3]; legal = 1;
        if (f3 == 1) legal = (f7 == 0);
        if (f3 == 5) begin
          legal = (f7 == 0 || f7 == 7'h20);
          if (f7 == 7'h20) e.alu = i_SRA;
        end
      end
      7'h33: begin
        writes = 1;
        if (en_m && f7 == 7'h01) begin legal = 1; e.is_mul = 1; e.mdu = f3; end
        else if (f7 == 0) begin legal = 1; e.is_alu = 1; e.alu = ops[f3]; end
        else if (f7 == 7'h20 && f3 == 0) begin legal = 1; e.is_alu = 1; e.alu = i_SUB; end
        else if (f7 == 7'h20 && f3 == 5) begin legal = 1; e.is_alu = 1; e.alu = i_SRA; end
      end
      default: ;
    endcase
    if (!legal) begin
      e.alu = i_ALUNOP; e.ls = i_LSNOP; e.br = 0; e.mdu = 0;
      {e.is_alu, e.is_ls, e.is_br, e.is_mul, e.is_lui, e.is_auipc, e.is_imm} = '0;
    end
    e.illegal = !legal;
    e.reg_we  = legal && writes && (e.rd != 0);
    return e;
  endfunction

  function automatic obs_t expected(bit en_m);
    obs_t e = '0;
    if (q.size() > 0) begin
      e = model_dec(q[0], en_m);
      e.valid = 1'b1;
    end
    e.ready = (q.size() < DEPTH);
    e.cnt   = cnt;
    return e;
  endfunction

  task automatic check_dut(string n, obs_t o, obs_t e);
    chk({n, ".valid"}, o.valid, e.valid);
    chk({n, ".ready"}, o.ready, e.ready);
    chk({n, ".count"}, o.cnt, e.cnt);
    if (e.valid) begin
      chk({n, ".pc"}, o.pc, e.pc);
      chk({n, ".regs"}, {o.rd, o.rs1, o.rs2}, {e.rd, e.rs1, e.rs2});
      chk({n, ".alu_op"}, o.alu, e.alu);
      chk({n, ".ls_op"}, o.ls, e.ls);
      chk({n, ".br_op"}, o.br, e.br);
      chk({n, ".mdu_op"}, o.mdu, e.mdu);
      chk({n, ".flags"}, {o.is_alu, o.is_ls, o.is_br, o.is_mul, o.is_lui, o.is_auipc, o.is_imm},
                         {e.is_alu, e.is_ls, e.is_br, e.is_mul, e.is_lui, e.is_auipc, e.is_imm});
      chk({n, ".reg_we"}, o.reg_we, e.reg_we);
      chk({n, ".imm"}, o.imm, e.imm);
      chk({n, ".illegal"}, o.illegal, e.illegal);
    end
  endtask

  task automatic check_now(string tag);
    check_dut({tag, ".m0"}, obs0, expected(1'b0));
    check_dut({tag, ".m1"}, obs1, expected(1'b1));
  endtask

  // Drive one cycle of inputs (called at negedge) and advance the FIFO model.
  task automatic drive(bit v, logic [31:0] ins, logic [31:0] pc, bit ordy, bit fl);
    bit do_push, do_pop;
    in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
    do_push = v && (q.size() < DEPTH) && !fl;
    do_pop  = (q.size() > 0) && ordy && !fl;
    if (fl) q.delete();
    else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) begin q.push_back({ins, pc}); cnt++; end
    end
  endtask

  task automatic step(bit v, logic [31:0] ins, logic [31:0] pc, bit ordy, bit fl, string tag);
    drive(v, ins, pc, ordy, fl);
    @(negedge clk);
    check_now(tag);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  opc [9] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
    logic [31:0] r = $urandom;
    r[6:0] = ($urandom_range(0, 9) == 0) ? 7'($urandom) : opc[$urandom_range(0, 8)];
    case ($urandom_range(0, 3))
      0: r[31:25] = 7'h00;
      1: r[31:25] = 7'h20;
      2: r[31:25] = 7'h01;
      default: ;
    endcase
    if ($urandom_range(0, 5) == 0) r[11:7] = 5'd0;
    return r;
  endfunction

  initial begin
    logic [31:0] saved;
    reset = 1'b0; in_valid = 0; in_instr = 0; in_pc = 0; out_ready = 0; flush = 0; cnt = 0;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    check_now("reset");
    chk("reset_pc", if1.out_pc, 32'h0);
    chk("reset_alu", if1.out_alu_op, i_ALUNOP);
    chk("reset_ls", if1.out_ls_op, i_LSNOP);
    reset = 1'b0;
    @(negedge clk);

    step(1, 32'h00500093, 32'h100, 1, 0, "addi");
    chk("addi_rd", if1.out_rd, 5'd1);
    chk("addi_alu", if1.out_alu_op, i_ADD);
    chk("addi_is_imm", if1.out_is_imm, 1'b1);
    chk("addi_imm", if1.out_imm, 32'd5);
    chk("addi_we", if1.out_reg_we, 1'b1);
    chk("addi_cnt", if1.decoded_count, 32'd1);
    step(0, 0, 0, 1, 0, "addi_pop");

    step(1, 32'h0020A423, 32'h104, 0, 0, "sw");
    chk("sw_ls", if1.out_ls_op, i_SW);
    chk("sw_imm", if1.out_imm, 32'd8);
    chk("sw_we", if1.out_reg_we, 1'b0);
    step(1, 32'hFE000EE3, 32'h108, 1, 0, "beq");
    chk("beq_is_br", if1.out_is_br, 1'b1);
    chk("beq_br_op", if1.out_br_op, 4'd0);
    chk("beq_imm", if1.out_imm, 32'hFFFFFFFC);
    step(0, 0, 0, 1, 0, "beq_pop");

    step(1, 32'h00100113, 32'h200, 0, 0, "bp1");
    step(1, 32'h00200193, 32'h204, 0, 0, "bp2");
    chk("bp_full_rdy", if1.in_ready, 1'b0);
    step(1, 32'h00300213, 32'h208, 0, 0, "bp3_held");
    chk("bp_head_pc", if1.out_pc, 32'h200);
    step(1, 32'h00300213, 32'h208, 1, 0, "bp_drain1");
    chk("bp_drain1_pc", if1.out_pc, 32'h204);
    step(1, 32'h00300213, 32'h208, 1, 0, "bp_drain2");
    chk("bp_third_pc", if1.out_pc, 32'h208);
    step(0, 0, 0, 1, 0, "bp_drain3");

    step(1, 32'h00100113, 32'h300, 0, 0, "fl1");
    step(1, 32'h00200193, 32'h304, 0, 0, "fl2");
    saved = cnt;
    step(1, 32'h00300213, 32'h308, 0, 1, "flush");
    chk("flush_valid", if1.out_valid, 1'b0);
    chk("flush_ready", if1.in_ready, 1'b1);
    chk("flush_cnt", if1.decoded_count, saved);

    step(1, 32'h00000000, 32'h400, 1, 0, "zero");
    chk("zero_illegal", if1.out_illegal, 1'b1);
    step(1, 32'h0020B423, 32'h404, 1, 0, "st_f3");
    chk("st_f3_illegal", if1.out_illegal, 1'b1);
    chk("st_f3_we", if1.out_reg_we, 1'b0);
    chk("st_f3_ls", if1.out_is_ls, 1'b0);
    step(1, 32'h022081B3, 32'h408, 1, 0, "mul");
    chk("mul_m0_illegal", if0.out_illegal, 1'b1);
    chk("mul_m1_is_mul", if1.out_is_mul, 1'b1);
    chk("mul_m1_mdu", if1.out_mdu_op, 3'd0);
    chk("mul_m1_we", if1.out_reg_we, 1'b1);
    chk("mul_m1_illegal", if1.out_illegal, 1'b0);
    step(0, 0, 0, 1, 0, "mul_pop");

    for (int k = 0; k < 3000; k++)
      step($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom_range(0, 2) != 0,
           $urandom_range(0, 24) == 0, "rnd");

    step(1, 32'h00500093, 32'h500, 0, 0, "pre_rst");
    drive(0, 0, 0, 0, 0);
    #2 reset = 1'b1;
    #1;
    q.delete();
    cnt = 0;
    check_now("rst_mid");
    chk("rst_mid_pc", if1.out_pc, 32'h0);
    chk("rst_mid_imm", if1.out_imm, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    step(1, 32'h00500093, 32'h600, 1, 0, "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
